// File: rtl/cv32e40x_aes_issue_ctrl.sv
// Issue and randomness controller between the core AES interface and the masked AES round datapath.
// Optional RNG repeat health check is built when CV32E40X_AES_RNG_CHECK_EN is defined.
module cv32e40x_aes_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int X_ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  core_valid_i,
  output logic                  core_ready_o,
  input  logic [X_ID_WIDTH-1:0] core_id_i,
  input  logic                  rng_valid_i,
  output logic                  rng_ready_o,
  input  logic [31:0]           rng_data_i,
  output logic                  aes_valid_o,
  input  logic                  aes_ready_i,
  output logic [X_ID_WIDTH-1:0] aes_id_o,
  output logic [7:0]            aes_mask_o,
  output logic [35:0]           aes_rand_o,
  input  logic                  aes_res_valid_i,
  output logic                  aes_res_ready_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  input  logic                  kill_i,
  output logic                  busy_o,
  output logic                  rng_err_o
);

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  localparam logic [3:0] LP_MAX  = 4'(MAX_INFLIGHT);
  localparam logic [6:0] LP_USE  = 7'd44;
  localparam logic [6:0] LP_WORD = 7'd32;

  state_t      r_state;
  logic [95:0] r_pool;
  logic [6:0]  r_cnt;
  logic [3:0]  r_inflight;
  logic [3:0]  r_drain;

  logic        w_run;
  logic        w_can_issue;
  logic        w_issue;
  logic        w_res_hs;
  logic        w_rng_acc;
  logic        w_word_add;
  logic [6:0]  w_base;
  logic [6:0]  w_cnt_next;
  logic [95:0] w_pool_next;
  logic [3:0]  w_inflight_next;

  assign w_run       = (r_state == ST_RUN);
  assign w_can_issue = (r_cnt >= LP_USE) && (r_inflight < LP_MAX) && w_run && !kill_i;

  assign aes_valid_o  = core_valid_i && w_can_issue;
  assign core_ready_o = aes_ready_i && w_can_issue;
  assign aes_id_o     = core_id_i;
  assign aes_mask_o   = r_pool[7:0];
  assign aes_rand_o   = r_pool[43:8];

  assign res_valid_o     = w_run ? aes_res_valid_i : 1'b0;
  assign aes_res_ready_o = w_run ? res_ready_i : 1'b1;

  assign rng_ready_o = (r_cnt <= 7'd64);
  assign busy_o      = (r_inflight != 4'd0) || !w_run;

  assign w_issue   = aes_valid_o && aes_ready_i;
  assign w_res_hs  = aes_res_valid_i && aes_res_ready_o;
  assign w_rng_acc = rng_valid_i && rng_ready_o;

`ifdef CV32E40X_AES_RNG_CHECK_EN
  logic [31:0] r_last;
  logic        r_have_last;
  logic        r_err;
  logic        w_dup;

  // A repeated word would hand the same mask bits to two operations, so it never enters the pool.
  assign w_dup      = w_rng_acc && r_have_last && (rng_data_i == r_last);
  assign w_word_add = w_rng_acc && !w_dup;
  assign rng_err_o  = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last      <= 32'd0;
      r_have_last <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_rng_acc) begin
      r_last      <= rng_data_i;
      r_have_last <= 1'b1;
      if (w_dup) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_word_add = w_rng_acc;
  assign rng_err_o  = 1'b0;
`endif

  // Bits above r_cnt are always zero, so a new word can simply be OR-ed in at the fill level.
  assign w_base      = w_issue ? (r_cnt - LP_USE) : r_cnt;
  assign w_pool_next = (w_issue ? (r_pool >> 44) : r_pool)
                     | (w_word_add ? ({64'd0, rng_data_i} << w_base) : 96'd0);
  assign w_cnt_next  = w_base + (w_word_add ? LP_WORD : 7'd0);

  assign w_inflight_next = r_inflight + {3'd0, w_issue} - {3'd0, w_res_hs};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_pool     <= 96'd0;
      r_cnt      <= 7'd0;
      r_inflight <= 4'd0;
      r_drain    <= 4'd0;
    end else begin
      r_pool     <= w_pool_next;
      r_cnt      <= w_cnt_next;
      r_inflight <= w_inflight_next;
      if (r_state == ST_RUN) begin
        // A result handshaken in the kill cycle is already excluded from w_inflight_next.
        if (kill_i && (w_inflight_next != 4'd0)) begin
          r_state <= ST_DRAIN;
          r_drain <= w_inflight_next;
        end
      end else begin
        if (w_res_hs) begin
          r_drain <= r_drain - 4'd1;
          if (r_drain == 4'd1) begin
            r_state <= ST_RUN;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_aes_issue_ctrl.sv
// Self-checking bench for cv32e40x_aes_issue_ctrl: directed vector table, corner sequences,
// and randomized traffic against a bit-queue reference model.
module tb_cv32e40x_aes_issue_ctrl;

  localparam int MAXF = 4;
  localparam int IDW  = 4;
`ifdef CV32E40X_AES_RNG_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           core_valid_i = 1'b0;
  logic           core_ready_o;
  logic [IDW-1:0] core_id_i = '0;
  logic           rng_valid_i = 1'b0;
  logic           rng_ready_o;
  logic [31:0]    rng_data_i = '0;
  logic           aes_valid_o;
  logic           aes_ready_i = 1'b0;
  logic [IDW-1:0] aes_id_o;
  logic [7:0]     aes_mask_o;
  logic [35:0]    aes_rand_o;
  logic           aes_res_valid_i = 1'b0;
  logic           aes_res_ready_o;
  logic           res_valid_o;
  logic           res_ready_i = 1'b0;
  logic           kill_i = 1'b0;
  logic           busy_o;
  logic           rng_err_o;

  cv32e40x_aes_issue_ctrl #(.MAX_INFLIGHT(MAXF), .X_ID_WIDTH(IDW)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_valid_i(core_valid_i), .core_ready_o(core_ready_o), .core_id_i(core_id_i),
    .rng_valid_i(rng_valid_i), .rng_ready_o(rng_ready_o), .rng_data_i(rng_data_i),
    .aes_valid_o(aes_valid_o), .aes_ready_i(aes_ready_i), .aes_id_o(aes_id_o),
    .aes_mask_o(aes_mask_o), .aes_rand_o(aes_rand_o),
    .aes_res_valid_i(aes_res_valid_i), .aes_res_ready_o(aes_res_ready_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .kill_i(kill_i), .busy_o(busy_o), .rng_err_o(rng_err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pool as an ordered bit queue (LSB first), in-flight as an integer.
  bit          m_q[$];
  int          m_infl;
  bit          m_drain;
  bit          m_err;
  logic [31:0] m_last;
  bit          m_have_last;

  bit          e_av, e_cr, e_rr, e_resv, e_resr, e_busy;
  logic [95:0] e_pool;

  function automatic logic [95:0] m_pool();
    logic [95:0] p;
    p = '0;
    for (int i = 0; i < m_q.size() && i < 96; i++) p[i] = m_q[i];
    return p;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_infl = 0;
    m_drain = 0;
    m_err = 0;
    m_last = '0;
    m_have_last = 0;
  endtask

  task automatic drive(input bit rv, input logic [31:0] rd, input bit cv, input bit ar,
                       input bit resv, input bit resr, input bit kl);
    bit can;
    rng_valid_i = rv; rng_data_i = rd; core_valid_i = cv; aes_ready_i = ar;
    aes_res_valid_i = resv; res_ready_i = resr; kill_i = kl;
    core_id_i = IDW'($urandom);
    #2;
    can    = (m_q.size() >= 44) && (m_infl < MAXF) && !m_drain && !kl;
    e_av   = cv && can;
    e_cr   = ar && can;
    e_rr   = (m_q.size() <= 64);
    e_resv = m_drain ? 1'b0 : resv;
    e_resr = m_drain ? 1'b1 : resr;
    e_busy = (m_infl != 0) || m_drain;
    e_pool = m_pool();
    chk("aes_valid", 64'(aes_valid_o), 64'(e_av));
    chk("core_ready", 64'(core_ready_o), 64'(e_cr));
    chk("rng_ready", 64'(rng_ready_o), 64'(e_rr));
    chk("res_valid", 64'(res_valid_o), 64'(e_resv));
    chk("aes_res_ready", 64'(aes_res_ready_o), 64'(e_resr));
    chk("busy", 64'(busy_o), 64'(e_busy));
    chk("rng_err", 64'(rng_err_o), 64'(m_err));
    chk("aes_id", 64'(aes_id_o), 64'(core_id_i));
    chk("mask", 64'(aes_mask_o), 64'(e_pool[7:0]));
    chk("rand", 64'(aes_rand_o), 64'(e_pool[43:8]));
  endtask

  task automatic adv();
    bit issue, hs, acc;
    issue = e_av && aes_ready_i;
    hs    = aes_res_valid_i && e_resr;
    acc   = rng_valid_i && e_rr;
    if (issue) repeat (44) void'(m_q.pop_front());
    if (acc) begin
      if (CHK_EN && m_have_last && (rng_data_i == m_last)) m_err = 1;
      else for (int i = 0; i < 32; i++) m_q.push_back(rng_data_i[i]);
      m_last = rng_data_i;
      m_have_last = 1;
    end
    m_infl = m_infl + int'(issue) - int'(hs);
    if (!m_drain) begin
      if (kill_i && m_infl > 0) m_drain = 1;
    end else if (m_infl == 0) begin
      m_drain = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    rng_valid_i = 0; core_valid_i = 0; aes_ready_i = 0;
    aes_res_valid_i = 0; res_ready_i = 0; kill_i = 0; rng_data_i = '0;
    #2;
    chk("rst_aes_valid", 64'(aes_valid_o), 64'd0);
    chk("rst_core_ready", 64'(core_ready_o), 64'd0);
    chk("rst_rng_ready", 64'(rng_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_rng_err", 64'(rng_err_o), 64'd0);
    chk("rst_res_valid", 64'(res_valid_o), 64'd0);
    chk("rst_res_ready", 64'(aes_res_ready_o), 64'd0);
    chk("rst_mask", 64'(aes_mask_o), 64'd0);
    chk("rst_rand", 64'(aes_rand_o), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          rv;
    logic [31:0] rd;
    bit          cv, ar, resv, resr, kl;
    bit          x_av, x_cr, x_rr, x_resv, x_resr, x_busy;
    bit          chk_d;
    logic [7:0]  x_mask;
    logic [35:0] x_rand;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int guard;
    tbl[0] = '{1, 32'h89AB_CDEF, 1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0,  0, 8'h00, 36'h0};
    tbl[1] = '{1, 32'h0123_4567, 1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0,  0, 8'h00, 36'h0};
    tbl[2] = '{0, 32'h0,         1, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0,  1, 8'hEF, 36'h5_6789_ABCD};
    tbl[3] = '{1, 32'hCAFE_F00D, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 1,  1, 8'h34, 36'h0_0000_0012};
    tbl[4] = '{1, 32'h1111_2222, 0, 1, 0, 0, 0,  0, 1, 1, 0, 0, 1,  1, 8'h34, 36'hF_EF00_D012};
    tbl[5] = '{1, 32'h3333_4444, 0, 1, 1, 1, 0,  0, 1, 0, 1, 1, 1,  0, 8'h00, 36'h0};
    tbl[6] = '{0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 8'h00, 36'h0};

    model_reset();
    #3;
    do_reset();

    // Directed table from reset: first issue in cycle 2 with mask A[7:0], rand {B[11:0], A[31:8]}.
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rv, tbl[i].rd, tbl[i].cv, tbl[i].ar, tbl[i].resv, tbl[i].resr, tbl[i].kl);
      chk($sformatf("tbl%0d_av", i), 64'(aes_valid_o), 64'(tbl[i].x_av));
      chk($sformatf("tbl%0d_cr", i), 64'(core_ready_o), 64'(tbl[i].x_cr));
      chk($sformatf("tbl%0d_rr", i), 64'(rng_ready_o), 64'(tbl[i].x_rr));
      chk($sformatf("tbl%0d_resv", i), 64'(res_valid_o), 64'(tbl[i].x_resv));
      chk($sformatf("tbl%0d_resr", i), 64'(aes_res_ready_o), 64'(tbl[i].x_resr));
      chk($sformatf("tbl%0d_busy", i), 64'(busy_o), 64'(tbl[i].x_busy));
      if (tbl[i].chk_d) begin
        chk($sformatf("tbl%0d_mask", i), 64'(aes_mask_o), 64'(tbl[i].x_mask));
        chk($sformatf("tbl%0d_rand", i), 64'(aes_rand_o), 64'(tbl[i].x_rand));
      end
      adv();
    end

    // Pool short of 44 bits stalls issue; one more word makes it issuable next cycle.
    do_reset();
    drive(1, 32'hA1A1_0001, 0, 1, 0, 0, 0); adv();
    drive(1, 32'hB2B2_0002, 0, 1, 0, 0, 0); adv();
    drive(1, 32'hC3C3_0003, 1, 1, 0, 0, 0); adv();
    drive(1, 32'hD4D4_0004, 1, 1, 0, 0, 0); adv();
    drive(0, 32'h0, 1, 1, 0, 0, 0);
    chk("stall_cnt40", 64'(dut.r_cnt), 64'd40);
    chk("stall_av", 64'(aes_valid_o), 64'd0);
    chk("stall_cr", 64'(core_ready_o), 64'd0);
    adv();
    drive(1, 32'hE5E5_0005, 1, 1, 0, 0, 0);
    chk("stall_acc_av", 64'(aes_valid_o), 64'd0);
    adv();
    drive(0, 32'h0, 1, 1, 0, 0, 0);
    chk("refill_cnt72", 64'(dut.r_cnt), 64'd72);
    chk("refill_av", 64'(aes_valid_o), 64'd1);
    adv();

    // In-flight limit: 5th request waits; result returns, issue follows once count is 3.
    do_reset();
    guard = 0;
    while (m_infl < MAXF && guard < 40) begin
      drive(1, $urandom, 1, 1, 0, 0, 0); adv(); guard++;
    end
    if (m_infl < MAXF) begin
      n_tests++; n_fail++;
      $display("FAIL limit_fill_timeout: got %0d expected %0d", m_infl, MAXF);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 1, 1, 0, 0, 0);
      chk("limit_stall_av", 64'(aes_valid_o), 64'd0);
      adv();
    end
    drive(0, 32'h0, 1, 1, 1, 1, 0);
    chk("limit_res_cycle_av", 64'(aes_valid_o), 64'd0);
    chk("limit_res_fwd", 64'(res_valid_o), 64'd1);
    adv();
    drive(0, 32'h0, 1, 1, 0, 0, 0);
    chk("limit_resume_av", 64'(aes_valid_o), 64'd1);
    adv();

    // Kill with 3 in flight: drain absorbs 3 results, a second kill is ignored, then issue resumes.
    do_reset();
    guard = 0;
    while (m_infl < 3 && guard < 40) begin
      drive(1, $urandom, 1, 1, 0, 0, 0); adv(); guard++;
    end
    if (m_infl < 3) begin
      n_tests++; n_fail++;
      $display("FAIL kill_fill_timeout: got %0d expected %0d", m_infl, 3);
    end
    drive(1, $urandom, 1, 1, 0, 0, 1);
    chk("kill_av", 64'(aes_valid_o), 64'd0);
    adv();
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom, 1, 1, (i == 1 || i >= 3), 0, (i == 2));
      chk("drain_res_valid", 64'(res_valid_o), 64'd0);
      chk("drain_res_ready", 64'(aes_res_ready_o), 64'd1);
      chk("drain_av", 64'(aes_valid_o), 64'd0);
      chk("drain_busy", 64'(busy_o), 64'd1);
      adv();
    end
    drive(1, $urandom, 1, 1, 0, 0, 0);
    chk("drain_exit_av", 64'(aes_valid_o), 64'd1);
    chk("drain_exit_busy", 64'(busy_o), 64'd0);
    adv();

    // Simultaneous accept and issue at cnt 60: new word lands at pool bit 16.
    do_reset();
    drive(1, 32'h0000_0101, 0, 1, 0, 0, 0); adv();
    drive(1, 32'h0000_0202, 0, 1, 0, 0, 0); adv();
    drive(1, 32'h0000_0303, 0, 1, 0, 0, 0); adv();
    drive(1, 32'h0000_0404, 1, 1, 0, 0, 0); adv();
    drive(1, 32'h0000_0505, 0, 1, 0, 0, 0); adv();
    drive(1, 32'h0000_0606, 1, 1, 0, 0, 0); adv();
    drive(1, 32'h0000_0707, 0, 1, 0, 0, 0); adv();
    drive(1, 32'h0000_0808, 1, 1, 0, 0, 0); adv();
    drive(1, 32'h0000_0909, 0, 1, 0, 0, 0); adv();
    drive(1, 32'h5A5A_C3C3, 1, 1, 0, 0, 0);
    chk("sim_cnt60", 64'(dut.r_cnt), 64'd60);
    chk("sim_av", 64'(aes_valid_o), 64'd1);
    chk("sim_rr", 64'(rng_ready_o), 64'd1);
    adv();
    chk("sim_cnt48", 64'(dut.r_cnt), 64'd48);
    chk("sim_word_pos", 64'(dut.r_pool[47:16]), 64'h5A5A_C3C3);
    drive(0, 32'h0, 0, 0, 0, 0, 0); adv();

    // Repeated RNG word.
    do_reset();
    drive(1, 32'h1234_5678, 0, 0, 0, 0, 0); adv();
    drive(1, 32'h1234_5678, 0, 0, 0, 0, 0); adv();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
`ifdef CV32E40X_AES_RNG_CHECK_EN
    chk("dup_cnt32", 64'(dut.r_cnt), 64'd32);
    chk("dup_err", 64'(rng_err_o), 64'd1);
    adv();
    drive(1, 32'h8765_4321, 0, 0, 0, 0, 0); adv();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    chk("dup_err_sticky", 64'(rng_err_o), 64'd1);
    chk("dup_cnt64", 64'(dut.r_cnt), 64'd64);
`else
    chk("nodup_cnt64", 64'(dut.r_cnt), 64'd64);
    chk("nodup_err", 64'(rng_err_o), 64'd0);
`endif
    adv();

    // Randomized traffic against the model, with a mid-run reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rd;
      if (i == 1500) do_reset();
      rd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      drive(($urandom_range(0, 9) < 7), rd, 1'($urandom), 1'($urandom),
            (m_infl > 0) && 1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
